ipr_nvme_cq_multi_sm: RTL and testbench

//  Multi-queue NVMe completion-queue consumer. Takes CQE dword3 entries tagged with a queue ID.
//  Per queue it checks the phase tag, tracks the head pointer with wrap/phase flip, emits a

---
 rtl/ipr_nvme_cq_multi_sm.sv | 171 +++++++++++++++++
 tb/tb_ipr_nvme_cq_multi_sm.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ipr_nvme_cq_multi_sm.sv
// Multi-queue NVMe CQ consumer: phase check, head/phase tracking, completion + doorbell.
// Optional status-error counting is enabled by defining NVME_CQ_ERR_CNT_EN.
module ipr_nvme_cq_multi_sm #(
    parameter int NUM_Q       = 4,
    parameter int QID_W       = 2,
    parameter int ADMIN_DEPTH = 16,
    parameter int IO_DEPTH    = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk_in,
    input  logic             resetb,
    input  logic             cqe_valid,
    output logic             cqe_ready,
    input  logic [QID_W-1:0] cqe_qid,
    input  logic [31:0]      cqe_dw3,
    output logic             cpl_valid,
    input  logic             cpl_ready,
    output logic [QID_W-1:0] cpl_qid,
    output logic [15:0]      cpl_cid,
    output logic [14:0]      cpl_status,
    output logic             db_valid,
    input  logic             db_ready,
    output logic [QID_W-1:0] db_qid,
    output logic [15:0]      db_head,
    output logic [CNT_W-1:0] cpl_cnt,
    output logic [CNT_W-1:0] stale_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        EMIT,
        DOORBELL
    } state_t;

    localparam int          NQ         = 1 << QID_W;
    localparam logic [15:0] ADMIN_LAST = 16'(ADMIN_DEPTH - 1);
    localparam logic [15:0] IO_LAST    = 16'(IO_DEPTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [QID_W-1:0] qid_q;
    logic [31:0]      dw3_q;
    logic [15:0]      head_q [NQ];
    logic [NQ-1:0]    phase_q;
    logic [15:0]      db_head_q;
    logic [CNT_W-1:0] cpl_cnt_q;
    logic [CNT_W-1:0] stale_cnt_q;

    logic             in_range;
    logic             hit;
    logic             wrap;
    logic [15:0]      cur_head;
    logic [15:0]      last_idx;
    logic [15:0]      nxt_head;

    always_comb begin
        in_range = {{(32-QID_W){1'b0}}, qid_q} < 32'(NUM_Q);
        hit      = in_range && (dw3_q[16] == phase_q[qid_q]);
        cur_head = head_q[qid_q];
        last_idx = (qid_q == '0) ? ADMIN_LAST : IO_LAST;
        wrap     = (cur_head == last_idx);
        nxt_head = wrap ? 16'd0 : cur_head + 16'd1;
    end

    always_ff @(posedge clk_in) begin
        if (resetb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cqe_ready = 1'b0;
        cpl_valid = 1'b0;
        db_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Ready is masked while reset is held so reset outputs read 0.
                cqe_ready = ~resetb;
                if (cqe_valid) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = hit ? EMIT : IDLE;
            end
            EMIT: begin
                cpl_valid = 1'b1;
                if (cpl_ready) begin
                    state_d = DOORBELL;
                end
            end
            DOORBELL: begin
                db_valid = 1'b1;
                if (db_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (resetb) begin
            qid_q       <= '0;
            dw3_q       <= '0;
            phase_q     <= '1;
            db_head_q   <= '0;
            cpl_cnt_q   <= '0;
            stale_cnt_q <= '0;
            for (int i = 0; i < NQ; i++) begin
                head_q[i] <= '0;
            end
        end else begin
            if (state_q == IDLE && cqe_valid) begin
                qid_q <= cqe_qid;
                dw3_q <= cqe_dw3;
            end
            if (state_q == CHECK) begin
                if (hit) begin
                    head_q[qid_q] <= nxt_head;
                    db_head_q     <= nxt_head;
                    cpl_cnt_q     <= cpl_cnt_q + 1'b1;
                    if (wrap) begin
                        phase_q[qid_q] <= ~phase_q[qid_q];
                    end
                end else begin
                    stale_cnt_q <= stale_cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef NVME_CQ_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q;
    logic             err_pulse_q;

    // Registered so the pulse lines up with the first cpl_valid cycle.
    always_ff @(posedge clk_in) begin
        if (resetb) begin
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= (state_q == CHECK) && hit && (|dw3_q[31:17]);
            if ((state_q == CHECK) && hit && (|dw3_q[31:17])) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign err_cnt   = err_cnt_q;
    assign err_pulse = err_pulse_q;
`else
    assign err_cnt   = '0;
    assign err_pulse = 1'b0;
`endif

    assign cpl_qid    = qid_q;
    assign cpl_cid    = dw3_q[15:0];
    assign cpl_status = dw3_q[31:17];
    assign db_qid     = qid_q;
    assign db_head    = db_head_q;
    assign cpl_cnt    = cpl_cnt_q;
    assign stale_cnt  = stale_cnt_q;

endmodule

// File: tb/tb_ipr_nvme_cq_multi_sm.sv
// Directed bench for ipr_nvme_cq_multi_sm (NUM_Q=4, QID_W=3 so qid>=NUM_Q is reachable).
// Expectations for err_cnt/err_pulse follow NVME_CQ_ERR_CNT_EN.
module tb_ipr_nvme_cq_multi_sm;

`ifdef NVME_CQ_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        resetb = 1'b1;
    logic        cqe_valid = 1'b0;
    logic        cqe_ready;
    logic [2:0]  cqe_qid = '0;
    logic [31:0] cqe_dw3 = '0;
    logic        cpl_valid;
    logic        cpl_ready = 1'b1;
    logic [2:0]  cpl_qid;
    logic [15:0] cpl_cid;
    logic [14:0] cpl_status;
    logic        db_valid;
    logic        db_ready = 1'b1;
    logic [2:0]  db_qid;
    logic [15:0] db_head;
    logic [31:0] cpl_cnt;
    logic [31:0] stale_cnt;
    logic [31:0] err_cnt;
    logic        err_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cpl = 0;
    int exp_stale = 0;
    int exp_err = 0;
    int pulse_n = 0;
    int pulse_base = 0;
    int both_n = 0;
    int last_lat = 0;

    ipr_nvme_cq_multi_sm #(
        .NUM_Q      (4),
        .QID_W      (3),
        .ADMIN_DEPTH(16),
        .IO_DEPTH   (64),
        .CNT_W      (32)
    ) dut (
        .clk_in    (clk_in),
        .resetb    (resetb),
        .cqe_valid (cqe_valid),
        .cqe_ready (cqe_ready),
        .cqe_qid   (cqe_qid),
        .cqe_dw3   (cqe_dw3),
        .cpl_valid (cpl_valid),
        .cpl_ready (cpl_ready),
        .cpl_qid   (cpl_qid),
        .cpl_cid   (cpl_cid),
        .cpl_status(cpl_status),
        .db_valid  (db_valid),
        .db_ready  (db_ready),
        .db_qid    (db_qid),
        .db_head   (db_head),
        .cpl_cnt   (cpl_cnt),
        .stale_cnt (stale_cnt),
        .err_cnt   (err_cnt),
        .err_pulse (err_pulse)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (err_pulse) pulse_n++;
        if (cpl_valid && db_valid) both_n++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        resetb = 1'b1;
        repeat (2) @(negedge clk_in);
        resetb = 1'b0;
        exp_cpl = 0;
        exp_stale = 0;
        exp_err = 0;
        pulse_base = pulse_n;
    endtask

    // Returns at the negedge after the accepting edge (DUT in CHECK).
    task automatic push(input logic [2:0] q, input logic [31:0] d);
        int n;
        @(negedge clk_in);
        cqe_qid = q;
        cqe_dw3 = d;
        cqe_valid = 1'b1;
        n = 0;
        while (!cqe_ready && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        chk("push_ready", {31'd0, cqe_ready}, 32'd1);
        @(posedge clk_in);
        @(negedge clk_in);
        cqe_valid = 1'b0;
    endtask

    task automatic xact(input logic [2:0] q, input logic [31:0] d,
                        input logic [15:0] head);
        int n;
        push(q, d);
        exp_cpl++;
        if (d[31:17] != 15'd0) exp_err++;
        n = 0;
        while (!cpl_valid && n < 10) begin
            @(negedge clk_in);
            n++;
        end
        last_lat = n;
        chk("cpl_valid", {31'd0, cpl_valid}, 32'd1);
        chk("cpl_qid", {29'd0, cpl_qid}, {29'd0, q});
        chk("cpl_cid", {16'd0, cpl_cid}, {16'd0, d[15:0]});
        chk("cpl_status", {17'd0, cpl_status}, {17'd0, d[31:17]});
        @(negedge clk_in);
        n = 0;
        while (!db_valid && n < 10) begin
            @(negedge clk_in);
            n++;
        end
        chk("db_valid", {31'd0, db_valid}, 32'd1);
        chk("db_qid", {29'd0, db_qid}, {29'd0, q});
        chk("db_head", {16'd0, db_head}, {16'd0, head});
        @(negedge clk_in);
        chk("cpl_cnt", cpl_cnt, exp_cpl);
    endtask

    task automatic drop(input logic [2:0] q, input logic [31:0] d);
        push(q, d);
        exp_stale++;
        for (int i = 0; i < 4; i++) begin
            chk("drop_quiet", {31'd0, cpl_valid | db_valid}, 32'd0);
            @(negedge clk_in);
        end
        chk("stale_cnt", stale_cnt, exp_stale);
        chk("drop_cpl_cnt", cpl_cnt, exp_cpl);
    endtask

    initial begin
        repeat (3) @(negedge clk_in);
        chk("rst_ready", {31'd0, cqe_ready}, 32'd0);
        chk("rst_cpl_valid", {31'd0, cpl_valid}, 32'd0);
        chk("rst_db_valid", {31'd0, db_valid}, 32'd0);
        chk("rst_cpl_cnt", cpl_cnt, 32'd0);
        chk("rst_stale_cnt", stale_cnt, 32'd0);
        chk("rst_err_cnt", err_cnt, 32'd0);
        chk("rst_db_head", {16'd0, db_head}, 32'd0);
        resetb = 1'b0;
        @(negedge clk_in);
        chk("idle_ready", {31'd0, cqe_ready}, 32'd1);

        xact(3'd0, 32'h0001_0005, 16'd1);
        chk("latency", last_lat, 32'd1);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            xact(3'd0, 32'h0001_0000 | 32'(i), 16'((i + 1) % 16));
        end
        drop(3'd0, 32'h0001_00AA);
        xact(3'd0, 32'h0000_00BB, 16'd1);

        xact(3'd1, 32'h0001_0101, 16'd1);
        xact(3'd2, 32'h0001_0201, 16'd1);
        xact(3'd1, 32'h0001_0102, 16'd2);
        xact(3'd2, 32'h0001_0202, 16'd2);
        xact(3'd1, 32'h0001_0103, 16'd3);

        for (int i = 0; i < 64; i++) begin
            xact(3'd3, 32'h0001_0300 + 32'(i), 16'((i + 1) % 64));
        end
        drop(3'd3, 32'h0001_0399);

        // Backpressure on qid1, status 0x12, cid 0x55; qid1 head must go 3 -> 4.
        cpl_ready = 1'b0;
        push(3'd1, 32'h0025_0055);
        exp_cpl++;
        exp_err++;
        @(negedge clk_in);
        for (int i = 0; i < 10; i++) begin
            chk("stall_cpl_valid", {31'd0, cpl_valid}, 32'd1);
            chk("stall_cid", {16'd0, cpl_cid}, 32'h55);
            chk("stall_status", {17'd0, cpl_status}, 32'h12);
            chk("stall_qid", {29'd0, cpl_qid}, 32'd1);
            chk("stall_no_accept", {31'd0, cqe_ready | db_valid}, 32'd0);
            @(negedge clk_in);
        end
        db_ready = 1'b0;
        cpl_ready = 1'b1;
        @(negedge clk_in);
        for (int i = 0; i < 5; i++) begin
            chk("dbstall_valid", {31'd0, db_valid}, 32'd1);
            chk("dbstall_head", {16'd0, db_head}, 32'd4);
            chk("dbstall_qid", {29'd0, db_qid}, 32'd1);
            chk("dbstall_quiet", {31'd0, cqe_ready | cpl_valid}, 32'd0);
            @(negedge clk_in);
        end
        db_ready = 1'b1;
        @(negedge clk_in);
        chk("post_stall_ready", {31'd0, cqe_ready}, 32'd1);
        chk("post_stall_cnt", cpl_cnt, exp_cpl);

        drop(3'd5, 32'h0001_0009);

        xact(3'd2, 32'h0003_0007, 16'd3);
        chk("err_cnt", err_cnt, ERR_EN ? 32'(exp_err) : 32'd0);
        chk("err_pulses", pulse_n - pulse_base, ERR_EN ? exp_err : 0);

        cpl_ready = 1'b0;
        push(3'd1, 32'h0001_0033);
        @(negedge clk_in);
        chk("pre_rst_emit", {31'd0, cpl_valid}, 32'd1);
        resetb = 1'b1;
        @(negedge clk_in);
        chk("mid_rst_ready", {31'd0, cqe_ready}, 32'd0);
        chk("mid_rst_valids", {30'd0, cpl_valid, db_valid}, 32'd0);
        chk("mid_rst_cpl_cnt", cpl_cnt, 32'd0);
        chk("mid_rst_stale", stale_cnt, 32'd0);
        chk("mid_rst_err", {err_cnt[30:0], err_pulse}, 32'd0);
        chk("mid_rst_cid", {16'd0, cpl_cid}, 32'd0);
        resetb = 1'b0;
        cpl_ready = 1'b1;
        exp_cpl = 0;
        exp_stale = 0;
        exp_err = 0;
        xact(3'd1, 32'h0001_0002, 16'd1);

        chk("both_valid", both_n, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
